// File: rtl/xa_bf_ctrl_gen2.sv
// ============================================================================
//  Module      : xa_bf_ctrl_gen2
//  Description : Beam-forming sequence controller (spec wait, param transfer,
//                RAM fills and calcs per frame, abort on frame change).
//                Optional watchdog enabled by macro XA_BF_CTRL_WDT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xa_bf_ctrl_gen2 #(
  parameter int                   P_FRAME_W   = 4,
  parameter logic [P_FRAME_W-1:0] P_FRAME_MAX = 4'h7,
  parameter int                   P_CALC_W    = 5,
  parameter int                   P_CALC_NUM  = 2,
  parameter int                   P_RAM_NUM   = 2,
  parameter logic [19:0]          P_PAD_SIZE  = 20'd0
) (
  input  logic                 i_clk156m,
  input  logic                 i_arst_n,
  input  logic [P_FRAME_W-1:0] i_frame_time,
  input  logic                 i_system,
  input  logic                 i_sp_start,
  input  logic                 i_param_end,
  input  logic                 i_calc_end,
  input  logic [31:0]          i_frame_offset,
  output logic                 o_param_start,
  output logic                 o_calc_start,
  output logic                 o_sp_end,
  output logic [19:0]          o_pad_size,
  output logic                 o_end_ins,
  output logic [P_FRAME_W-1:0] o_frame_idx,
  output logic [P_CALC_W-1:0]  o_calc_idx,
  output logic [31:0]          o_frame_offset0,
  output logic                 o_abort
);

  typedef enum logic [4:0] {
    S_SPEC  = 5'b00001,
    S_TRANS = 5'b00010,
    S_RAM   = 5'b00100,
    S_CALC  = 5'b01000,
    S_JUDGE = 5'b10000
  } state_t;

  localparam logic [P_CALC_W-1:0] c_calc_num  = P_CALC_W'(P_CALC_NUM);
  localparam logic [P_CALC_W-1:0] c_calc_last = P_CALC_W'(P_CALC_NUM - 1);
  localparam logic [3:0]          c_ram_last  = 4'(P_RAM_NUM - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [P_CALC_W-1:0]   r_calc_cnt;
  logic [P_CALC_W-1:0]   w_calc_cnt_nxt;
  logic [3:0]            r_ram_cnt;
  logic [3:0]            w_ram_cnt_nxt;
  logic [P_FRAME_W-1:0]  r_frame;
  logic                  w_chg;
  logic                  w_abort;
  logic                  w_sp_end;
  logic                  w_wdt_exp;
  logic                  w_last_calc;

  assign w_chg       = (i_frame_time != r_frame);
  assign w_last_calc = (r_state == S_CALC) && (r_calc_cnt == c_calc_last);

`ifdef XA_BF_CTRL_WDT_EN
  logic [15:0] r_wdt;
  logic        w_wdt_cnt_en;

  assign w_wdt_cnt_en = (r_state == S_TRANS) || (r_state == S_RAM) || (r_state == S_CALC);
  assign w_wdt_exp    = w_wdt_cnt_en && (r_wdt == 16'hFFFF);

  always_ff @(posedge i_clk156m or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_wdt <= 16'd0;
    end else if ((w_state_nxt != r_state) || !w_wdt_cnt_en) begin
      r_wdt <= 16'd0;
    end else begin
      r_wdt <= r_wdt + 16'd1;
    end
  end
`else
  assign w_wdt_exp = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_calc_cnt_nxt = r_calc_cnt;
    w_ram_cnt_nxt  = r_ram_cnt;
    w_abort        = 1'b0;
    w_sp_end       = 1'b0;
    case (r_state)
      S_SPEC: begin
        if (!w_chg && (!i_system || i_sp_start)) begin
          w_state_nxt = S_TRANS;
        end
      end
      S_TRANS: begin
        if (i_param_end) begin
          w_state_nxt   = S_RAM;
          w_ram_cnt_nxt = 4'd0;
          w_sp_end      = i_system;
        end
      end
      S_RAM: begin
        if (i_sp_start) begin
          w_ram_cnt_nxt = r_ram_cnt + 4'd1;
          if (r_ram_cnt == c_ram_last) begin
            w_state_nxt = S_CALC;
          end else begin
            w_sp_end = 1'b1;
          end
        end
      end
      S_CALC: begin
        if (i_calc_end) begin
          w_state_nxt = S_JUDGE;
          w_sp_end    = 1'b1;
          if (r_calc_cnt != {P_CALC_W{1'b1}}) begin
            w_calc_cnt_nxt = r_calc_cnt + P_CALC_W'(1);
          end
        end
      end
      S_JUDGE: begin
        if (r_calc_cnt < c_calc_num) begin
          w_state_nxt   = S_RAM;
          w_ram_cnt_nxt = 4'd0;
        end else begin
          w_state_nxt    = S_SPEC;
          w_calc_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = S_SPEC;
        w_calc_cnt_nxt = '0;
        w_ram_cnt_nxt  = 4'd0;
      end
    endcase
    // Frame change (or watchdog) outranks every pulse seen in the same cycle
    if ((r_state != S_SPEC) && (w_chg || w_wdt_exp)) begin
      w_state_nxt    = S_SPEC;
      w_calc_cnt_nxt = '0;
      w_ram_cnt_nxt  = 4'd0;
      w_sp_end       = 1'b0;
      w_abort        = 1'b1;
    end
  end

  always_ff @(posedge i_clk156m or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state         <= S_SPEC;
      r_calc_cnt      <= '0;
      r_ram_cnt       <= 4'd0;
      r_frame         <= P_FRAME_MAX;
      o_param_start   <= 1'b0;
      o_calc_start    <= 1'b0;
      o_sp_end        <= 1'b0;
      o_pad_size      <= 20'd0;
      o_end_ins       <= 1'b0;
      o_frame_idx     <= '0;
      o_calc_idx      <= '0;
      o_frame_offset0 <= 32'd0;
      o_abort         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_calc_cnt    <= w_calc_cnt_nxt;
      r_ram_cnt     <= w_ram_cnt_nxt;
      r_frame       <= i_frame_time;
      o_param_start <= (r_state == S_SPEC) && (w_state_nxt == S_TRANS);
      o_calc_start  <= (r_state == S_RAM) && (w_state_nxt == S_CALC);
      if ((r_state == S_RAM) && (w_state_nxt == S_CALC)) begin
        o_frame_idx <= i_frame_time;
        o_calc_idx  <= r_calc_cnt;
      end
      o_sp_end        <= w_sp_end;
      o_abort         <= w_abort;
      o_end_ins       <= w_last_calc;
      o_pad_size      <= w_last_calc ? P_PAD_SIZE : 20'd0;
      // TA holds the SP offset at zero until the spec read completes
      o_frame_offset0 <= ((r_state == S_SPEC) && i_system) ? 32'd0 : i_frame_offset;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_xa_bf_ctrl_gen2.sv
// ============================================================================
//  Module      : tb_xa_bf_ctrl_gen2
//  Description : Directed scoreboard bench for xa_bf_ctrl_gen2 (FA and TA runs,
//                ignored pulses, last-calc pad/end-code, frame-change aborts).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xa_bf_ctrl_gen2;

  localparam logic [1:0] EV_PARAM = 2'd0;
  localparam logic [1:0] EV_CALC  = 2'd1;
  localparam logic [1:0] EV_SPEND = 2'd2;
  localparam logic [1:0] EV_ABORT = 2'd3;
  localparam logic [31:0] OFFS    = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] frame;
    logic [4:0] idx;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  frame_time;
  logic        sys;
  logic        sp_start;
  logic        param_end;
  logic        calc_end;
  logic [31:0] frame_offset;
  logic        param_start_o;
  logic        calc_start_o;
  logic        sp_end_o;
  logic [19:0] pad_size_o;
  logic        end_ins_o;
  logic [3:0]  frame_idx_o;
  logic [4:0]  calc_idx_o;
  logic [31:0] frame_offset0_o;
  logic        abort_o;

  int  total = 0;
  int  bad   = 0;
  ev_t q[$];

  always #5 clk = ~clk;

  xa_bf_ctrl_gen2 #(
    .P_FRAME_W  (4),
    .P_FRAME_MAX(4'h7),
    .P_CALC_W   (5),
    .P_CALC_NUM (3),
    .P_RAM_NUM  (2),
    .P_PAD_SIZE (20'd64)
  ) dut (
    .i_clk156m      (clk),
    .i_arst_n       (rst_n),
    .i_frame_time   (frame_time),
    .i_system       (sys),
    .i_sp_start     (sp_start),
    .i_param_end    (param_end),
    .i_calc_end     (calc_end),
    .i_frame_offset (frame_offset),
    .o_param_start  (param_start_o),
    .o_calc_start   (calc_start_o),
    .o_sp_end       (sp_end_o),
    .o_pad_size     (pad_size_o),
    .o_end_ins      (end_ins_o),
    .o_frame_idx    (frame_idx_o),
    .o_calc_idx     (calc_idx_o),
    .o_frame_offset0(frame_offset0_o),
    .o_abort        (abort_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_ev(input string tag, input logic [1:0] k, input logic [3:0] f,
                        input logic [4:0] idx);
    ev_t e;
    ev_t got;
    got = '{kind: k, frame: f, idx: idx};
    total++;
    if (q.size() == 0) begin
      bad++;
      $error("FAIL %s unexpected event observed=%h expected=none", tag, got);
    end else begin
      e = q.pop_front();
      assert (got === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, got, e);
      end
    end
  endtask

  // Output monitor: every pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (param_start_o) chk_ev("param_start", EV_PARAM, 4'd0, 5'd0);
      if (calc_start_o)  chk_ev("calc_start", EV_CALC, frame_idx_o, calc_idx_o);
      if (sp_end_o)      chk_ev("sp_end", EV_SPEND, 4'd0, 5'd0);
      if (abort_o)       chk_ev("abort", EV_ABORT, 4'd0, 5'd0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] k, input logic [3:0] f, input logic [4:0] idx);
    q.push_back('{kind: k, frame: f, idx: idx});
  endtask

  task automatic pulse_sp();
    sp_start = 1'b1;
    step(1);
    sp_start = 1'b0;
  endtask

  task automatic pulse_param();
    param_end = 1'b1;
    step(1);
    param_end = 1'b0;
  endtask

  task automatic pulse_calc();
    calc_end = 1'b1;
    step(1);
    calc_end = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    frame_time   = 4'h7;
    sys          = 1'b0;
    sp_start     = 1'b0;
    param_end    = 1'b0;
    calc_end     = 1'b0;
    frame_offset = OFFS;
    step(3);
    chk("rst_param_start", 32'(param_start_o), 32'd0);
    chk("rst_calc_start", 32'(calc_start_o), 32'd0);
    chk("rst_sp_end", 32'(sp_end_o), 32'd0);
    chk("rst_pad_size", 32'(pad_size_o), 32'd0);
    chk("rst_end_ins", 32'(end_ins_o), 32'd0);
    chk("rst_frame_idx", 32'(frame_idx_o), 32'd0);
    chk("rst_calc_idx", 32'(calc_idx_o), 32'd0);
    chk("rst_offset0", frame_offset0_o, 32'd0);
    chk("rst_abort", 32'(abort_o), 32'd0);

    // FA run: three calcs of two fills each
    push(EV_PARAM, 4'd0, 5'd0);
    rst_n = 1'b1;
    step(2);
    chk("fa_offset0", frame_offset0_o, OFFS);
    pulse_calc();
    pulse_param();
    for (int c = 0; c < 3; c++) begin
      if (c == 1) pulse_calc();
      push(EV_SPEND, 4'd0, 5'd0);
      pulse_sp();
      push(EV_CALC, 4'h7, 5'(c));
      pulse_sp();
      chk("end_ins_lag", 32'(end_ins_o), 32'd0);
      step(1);
      chk("end_ins_calc", 32'(end_ins_o), (c == 2) ? 32'd1 : 32'd0);
      chk("pad_calc", 32'(pad_size_o), (c == 2) ? 32'd64 : 32'd0);
      step(2);
      chk("end_ins_hold", 32'(end_ins_o), (c == 2) ? 32'd1 : 32'd0);
      chk("pad_hold", 32'(pad_size_o), (c == 2) ? 32'd64 : 32'd0);
      push(EV_SPEND, 4'd0, 5'd0);
      if (c == 2) push(EV_PARAM, 4'd0, 5'd0);
      pulse_calc();
      step(1);
      if (c == 2) begin
        chk("end_ins_after", 32'(end_ins_o), 32'd0);
        chk("pad_after", 32'(pad_size_o), 32'd0);
      end
    end
    step(2);
    chk("fa_queue_drained", 32'(q.size()), 32'd0);

    // Frame change while in S_TRANS, switching to TA
    sys        = 1'b1;
    frame_time = 4'h8;
    push(EV_ABORT, 4'd0, 5'd0);
    step(1);
    step(1);
    chk("ta_spec_offset0", frame_offset0_o, 32'd0);
    step(2);
    chk("ta_spec_offset0_hold", frame_offset0_o, 32'd0);
    push(EV_PARAM, 4'd0, 5'd0);
    pulse_sp();
    step(1);
    chk("ta_trans_offset0", frame_offset0_o, OFFS);
    push(EV_SPEND, 4'd0, 5'd0);
    pulse_param();
    push(EV_SPEND, 4'd0, 5'd0);
    pulse_sp();
    push(EV_CALC, 4'h8, 5'd0);
    pulse_sp();
    step(1);
    chk("ta_end_ins_first", 32'(end_ins_o), 32'd0);

    // Frame change coincident with i_calc_end: abort wins, no sp_end
    frame_time = 4'h9;
    push(EV_ABORT, 4'd0, 5'd0);
    pulse_calc();
    step(1);
    push(EV_PARAM, 4'd0, 5'd0);
    pulse_sp();
    push(EV_SPEND, 4'd0, 5'd0);
    pulse_param();
    push(EV_SPEND, 4'd0, 5'd0);
    pulse_sp();
    push(EV_CALC, 4'h9, 5'd0);
    pulse_sp();
    step(1);
    push(EV_SPEND, 4'd0, 5'd0);
    pulse_calc();
    step(3);
    chk("final_queue_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
